// File: rtl/dot2_sequencer.sv
// dot2_sequencer
//   Sequences a 2-lane multiply-add datapath (a1*b1 + a2*b2) over a job of
//   `len` beats and accumulates the per-beat sums into one dot-product result.
//   Datapath latency is fixed at two registers: products, then lane sum.
//   All arithmetic is modulo 2^WIDTH.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, len          job request and beat count (sampled only in IDLE)
//   busy                high while a job is in FEED, DRAIN or DONE
//   in_valid, in_ready  operand beat handshake (ready only in FEED)
//   a1, a2, b1, b2      operand beat
//   out_valid,out_ready result handshake (valid only in DONE)
//   out_data            accumulator value

// Per-lane product register.
// Ports: clk, rst, i_load (capture a*b), i_a, i_b, o_p (registered product).
module dot2_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_p
);
    logic [WIDTH-1:0] r_p;

    always_ff @(posedge clk) begin
        if (rst)         r_p <= '0;
        else if (i_load) r_p <= i_a * i_b;  // low WIDTH bits only
    end

    assign o_p = r_p;
endmodule

module dot2_sequencer #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int NUM_LANES = 2;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t                            r_state, w_next;
    logic [LEN_W-1:0]                  r_rem;
    logic [WIDTH-1:0]                  r_acc;
    logic [WIDTH-1:0]                  r_s;
    logic [2:1]                        r_vld_pipe;  // [1]: products valid, [2]: sum valid
    logic                              w_accept;
    logic [NUM_LANES-1:0][WIDTH-1:0]   w_a, w_b, w_p;

    assign w_accept = in_valid && (r_state == S_FEED);
    assign w_a      = {a2, a1};
    assign w_b      = {b2, b1};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dot2_lane #(.WIDTH(WIDTH)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_accept),
            .i_a    (w_a[g]),
            .i_b    (w_b[g]),
            .o_p    (w_p[g])
        );
    end

    // Next state and outputs
    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = (len == '0) ? S_DONE : S_FEED;
            end
            S_FEED: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (w_accept && r_rem == LEN_W'(1)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Both stages empty means the last sum has reached the accumulator.
                if (!r_vld_pipe[1] && !r_vld_pipe[2]) w_next = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Beat counter, pipeline tags, lane sum and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem      <= '0;
            r_vld_pipe <= '0;
            r_s        <= '0;
            r_acc      <= '0;
        end else begin
            r_vld_pipe[1] <= w_accept;
            r_vld_pipe[2] <= r_vld_pipe[1];
            r_s           <= w_p[0] + w_p[1];

            if (r_state == S_IDLE && start) begin
                r_rem <= len;
                r_acc <= '0;
            end else begin
                if (w_accept)      r_rem <= r_rem - LEN_W'(1);
                if (r_vld_pipe[2]) r_acc <= r_acc + r_s;
            end
        end
    end

    assign out_data = r_acc;
endmodule
